// File: rtl/reg_map_pkg.sv
// Peripheral address map and shared types for the CPU-side peripheral decoder.
// Pure declarations, no logic or latency of its own.
// No flow control here; consumers apply the decode during request capture.
package reg_map_pkg;

    // Region selectors on bus_addr[31:20]
    localparam logic [11:0] REGION_RST  = 12'hf80;
    localparam logic [11:0] REGION_ILA  = 12'hf81;
    localparam logic [11:0] REGION_SRAM = 12'hf82;

    // Offset of the reset-control register inside the local region
    localparam logic [19:0] R_RESET_CTRL = 20'h0_0000;

    // Read data returned for unmapped or timed-out reads
    localparam logic [31:0] UNMAPPED_RDATA_DFLT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        TGT_LOCAL = 2'd0,
        TGT_ILA   = 2'd1,
        TGT_SRAM  = 2'd2,
        TGT_NONE  = 2'd3
    } tgt_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } bus_state_e;

    // Map a full byte address to the target that serves it; unmapped local
    // offsets fall out as TGT_NONE so the FSM has a single error path.
    function automatic tgt_e decode_tgt(input logic [31:0] addr);
        tgt_e t;
        case (addr[31:20])
            REGION_RST:  t = (addr[19:0] == R_RESET_CTRL) ? TGT_LOCAL : TGT_NONE;
            REGION_ILA:  t = TGT_ILA;
            REGION_SRAM: t = TGT_SRAM;
            default:     t = TGT_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/periph_bus_decoder_if.sv
// CPU native bus plus the two external target buses of the peripheral decoder.
// Wires only, no latency.
// CPU side is valid/ready; targets are sel/ready with sel held until ready.
interface periph_bus_decoder_if;

    // CPU request / response
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    // ILA target
    logic        ila_sel;
    logic [19:0] ila_addr;
    logic [31:0] ila_wdata;
    logic [3:0]  ila_wstrb;
    logic [31:0] ila_rdata;
    logic        ila_ready;

    // Scratch RAM target
    logic        sram_sel;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    // Decoder view
    modport slave (
        input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata, bus_err,
        output ila_sel, ila_addr, ila_wdata, ila_wstrb,
        input  ila_rdata, ila_ready,
        output sram_sel, sram_addr, sram_wdata, sram_wstrb,
        input  sram_rdata, sram_ready
    );

    // CPU and target view
    modport master (
        output bus_valid, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata, bus_err,
        input  ila_sel, ila_addr, ila_wdata, ila_wstrb,
        output ila_rdata, ila_ready,
        input  sram_sel, sram_addr, sram_wdata, sram_wstrb,
        output sram_rdata, sram_ready
    );

endinterface

// File: rtl/rst_ctrl_reg.sv
// Byte-strobed local control register with zero-extended read-back.
// Write takes effect on the clock edge after we; read-back is combinational.
// No backpressure: a write is always accepted in the cycle we is high.
module rst_ctrl_reg #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic [W-1:0]  q,
    output logic [31:0]   rdata
);

    logic [31:0] cur_ext;
    logic [31:0] nxt_ext;
    logic        unused_hi;

    // Merge strobed bytes over the current value in a full 32-bit view
    always_comb begin
        cur_ext        = '0;
        cur_ext[W-1:0] = q;
        nxt_ext        = cur_ext;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                nxt_ext[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    // Bits above W have no storage; writes to them are discarded
    assign unused_hi = ^nxt_ext;
    assign rdata     = cur_ext;

    // Register update
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INIT;
        end else if (we) begin
            q <= nxt_ext[W-1:0];
        end
    end

endmodule

// File: rtl/periph_bus_decoder.sv
// Routes CPU accesses to ILA, scratch RAM or the local reset-control register.
// Latency valid->ready: 2 cycles local/unmapped, 2 + target wait for external.
// One access in flight; CPU holds valid until the one-cycle ready strobe.
module periph_bus_decoder
    import reg_map_pkg::*;
#(
    parameter int                     RST_CTRL_W     = 8,
    parameter logic [RST_CTRL_W-1:0]  RST_CTRL_INIT  = '0,
    parameter int                     TIMEOUT_CYCLES = 256,
    parameter logic [31:0]            UNMAPPED_RDATA = UNMAPPED_RDATA_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    periph_bus_decoder_if.slave    bif,
    output logic [RST_CTRL_W-1:0]  rst_ctrl
);

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_ACCESS = S_ACCESS;
    localparam logic [1:0] ST_RESP   = S_RESP;

    // TIMEOUT_CYCLES-1 always fits in clog2(TIMEOUT_CYCLES) bits for values >= 2
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q;
    tgt_e              tgt_q;
    logic [19:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              in_access;
    logic              is_read;
    logic              tgt_ready;
    logic [31:0]       tgt_rdata;
    logic              reg_we;
    logic [31:0]       reg_rdata;

    assign in_access = (state_q == ST_ACCESS);
    assign is_read   = (wstrb_q == 4'b0000);

    // Only the selected target's ready/rdata are observed; the other is ignored
    always_comb begin
        tgt_ready = 1'b0;
        tgt_rdata = '0;
        case (tgt_q)
            TGT_ILA: begin
                tgt_ready = bif.ila_ready;
                tgt_rdata = bif.ila_rdata;
            end
            TGT_SRAM: begin
                tgt_ready = bif.sram_ready;
                tgt_rdata = bif.sram_rdata;
            end
            default: begin
                tgt_ready = 1'b0;
                tgt_rdata = '0;
            end
        endcase
    end

    // Local register writes commit during the single ACCESS cycle
    assign reg_we = in_access && (tgt_q == TGT_LOCAL) && !is_read;

    rst_ctrl_reg #(
        .W    (RST_CTRL_W),
        .INIT (RST_CTRL_INIT)
    ) u_rst_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .we    (reg_we),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .q     (rst_ctrl),
        .rdata (reg_rdata)
    );

    // Request capture, target wait with timeout, and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bif.bus_valid) begin
                        addr_q  <= bif.bus_addr[19:0];
                        wdata_q <= bif.bus_wdata;
                        wstrb_q <= bif.bus_wstrb;
                        tgt_q   <= decode_tgt(bif.bus_addr);
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    case (tgt_q)
                        TGT_ILA, TGT_SRAM: begin
                            // Ready is checked first so a late ready beats the timeout
                            if (tgt_ready) begin
                                rdata_q <= is_read ? tgt_rdata : '0;
                                err_q   <= 1'b0;
                                state_q <= ST_RESP;
                            end else if (cnt_q == CNT_LAST) begin
                                rdata_q <= is_read ? UNMAPPED_RDATA : '0;
                                err_q   <= 1'b1;
                                state_q <= ST_RESP;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        TGT_LOCAL: begin
                            rdata_q <= is_read ? reg_rdata : '0;
                            err_q   <= 1'b0;
                            state_q <= ST_RESP;
                        end
                        default: begin
                            rdata_q <= is_read ? UNMAPPED_RDATA : '0;
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    endcase
                end
                ST_RESP: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Response strobe and error pulse are confined to the RESP cycle
    assign bif.bus_ready = (state_q == ST_RESP);
    assign bif.bus_err   = (state_q == ST_RESP) && err_q;
    assign bif.bus_rdata = rdata_q;

    // Targets only ever see latched request fields
    assign bif.ila_sel    = in_access && (tgt_q == TGT_ILA);
    assign bif.ila_addr   = addr_q;
    assign bif.ila_wdata  = wdata_q;
    assign bif.ila_wstrb  = wstrb_q;

    assign bif.sram_sel   = in_access && (tgt_q == TGT_SRAM);
    assign bif.sram_addr  = addr_q;
    assign bif.sram_wdata = wdata_q;
    assign bif.sram_wstrb = wstrb_q;

endmodule

// File: tb/tb_periph_bus_decoder.sv
// Randomized bench for periph_bus_decoder against an address-map level model.
// Drives and samples on the falling clock edge.
// Plays both CPU and the two targets, injecting ignored ready on the idle target.
module tb_periph_bus_decoder;
    import reg_map_pkg::*;

    localparam int          T     = 256;
    localparam logic [7:0]  RINIT = 8'h5A;
    localparam logic [31:0] DEAD  = 32'hDEAD_BEEF;
    localparam int          NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rst_ctrl;

    always #5 clk = ~clk;

    periph_bus_decoder_if bif ();

    periph_bus_decoder #(
        .RST_CTRL_W     (8),
        .RST_CTRL_INIT  (RINIT),
        .TIMEOUT_CYCLES (T),
        .UNMAPPED_RDATA (DEAD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bif      (bif),
        .rst_ctrl (rst_ctrl)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] model_rc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // kind: 0 local reg, 1 ILA, 2 scratch RAM, 3 unmapped
    function automatic int region_of(input logic [31:0] a);
        if (a[31:20] == 12'hf80) return (a[19:0] == 20'h0) ? 0 : 3;
        if (a[31:20] == 12'hf81) return 1;
        if (a[31:20] == 12'hf82) return 2;
        return 3;
    endfunction

    // One CPU access; wait_cyc is the number of ACCESS cycles the target stalls
    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int wait_cyc);
        int          kind;
        bit          rd;
        bit          tmo;
        int          exp_lat;
        int          exp_sel;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [31:0] tdat;
        int          lat;
        bit          done;
        bit          ila_on;
        bit          sram_on;

        kind = region_of(a);
        rd   = (ws == 4'b0000);
        tdat = $urandom;
        tmo  = 1'b0;
        if (kind == 1 || kind == 2) begin
            tmo     = (wait_cyc > T - 1);
            exp_lat = tmo ? T + 1 : wait_cyc + 2;
            exp_sel = tmo ? T : wait_cyc + 1;
            exp_rd  = !rd ? 32'h0 : (tmo ? DEAD : tdat);
            exp_err = tmo;
        end else if (kind == 0) begin
            exp_lat = 2;
            exp_sel = 0;
            exp_rd  = rd ? {24'h0, model_rc} : 32'h0;
            exp_err = 1'b0;
            if (ws[0]) model_rc = wd[7:0];
        end else begin
            exp_lat = 2;
            exp_sel = 0;
            exp_rd  = rd ? DEAD : 32'h0;
            exp_err = 1'b1;
        end

        bif.bus_valid = 1'b1;
        bif.bus_addr  = a;
        bif.bus_wdata = wd;
        bif.bus_wstrb = ws;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < T + 20) begin
            @(negedge clk);
            lat++;
            ila_on  = (kind == 1) && (lat <= exp_sel);
            sram_on = (kind == 2) && (lat <= exp_sel);
            check("ila_sel", {31'h0, bif.ila_sel}, {31'h0, ila_on});
            check("sram_sel", {31'h0, bif.sram_sel}, {31'h0, sram_on});
            if (ila_on) check("ila_addr", {12'h0, bif.ila_addr}, {12'h0, a[19:0]});
            if (sram_on) check("sram_addr", {12'h0, bif.sram_addr}, {12'h0, a[19:0]});
            if (lat == 1 && ila_on) begin
                check("ila_wdata", bif.ila_wdata, wd);
                check("ila_wstrb", {28'h0, bif.ila_wstrb}, {28'h0, ws});
            end
            if (lat == 1 && sram_on) begin
                check("sram_wdata", bif.sram_wdata, wd);
                check("sram_wstrb", {28'h0, bif.sram_wstrb}, {28'h0, ws});
            end
            check("bus_ready", {31'h0, bif.bus_ready}, {31'h0, (lat == exp_lat)});
            check("bus_err", {31'h0, bif.bus_err}, {31'h0, (lat == exp_lat) && exp_err});
            if (bif.bus_ready) begin
                check("bus_rdata", bif.bus_rdata, exp_rd);
                check("latency", lat, exp_lat);
                bif.bus_valid = 1'b0;
                done = 1'b1;
            end
            // Target side: ready on the chosen ACCESS cycle, noise on the other target
            bif.ila_ready  = $urandom_range(0, 1);
            bif.ila_rdata  = $urandom;
            bif.sram_ready = $urandom_range(0, 1);
            bif.sram_rdata = $urandom;
            if (kind == 1) begin
                bif.ila_ready = (!done && lat - 1 == wait_cyc);
                bif.ila_rdata = (lat - 1 == wait_cyc) ? tdat : $urandom;
            end
            if (kind == 2) begin
                bif.sram_ready = (!done && lat - 1 == wait_cyc);
                bif.sram_rdata = (lat - 1 == wait_cyc) ? tdat : $urandom;
            end
        end
        check("resp_seen", {31'h0, done}, 32'h1);
        bif.bus_valid  = 1'b0;
        bif.ila_ready  = 1'b0;
        bif.sram_ready = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {31'h0, bif.bus_ready}, 32'h0);
        check("rst_ctrl", {24'h0, rst_ctrl}, {24'h0, model_rc});
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;
        int          w;

        rst            = 1'b1;
        bif.bus_valid  = 1'b0;
        bif.bus_addr   = '0;
        bif.bus_wdata  = '0;
        bif.bus_wstrb  = '0;
        bif.ila_ready  = 1'b0;
        bif.ila_rdata  = '0;
        bif.sram_ready = 1'b0;
        bif.sram_rdata = '0;
        model_rc       = RINIT;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_bus_ready", {31'h0, bif.bus_ready}, 32'h0);
        check("rst_bus_err", {31'h0, bif.bus_err}, 32'h0);
        check("rst_bus_rdata", bif.bus_rdata, 32'h0);
        check("rst_ila_sel", {31'h0, bif.ila_sel}, 32'h0);
        check("rst_sram_sel", {31'h0, bif.sram_sel}, 32'h0);
        check("rst_rst_ctrl", {24'h0, rst_ctrl}, {24'h0, RINIT});
        rst = 1'b0;
        @(negedge clk);

        // Reset-control write then read-back
        access(32'hf800_0000, 32'h0000_00A5, 4'b0001, 0);
        check("rc_after_write", {24'h0, rst_ctrl}, 32'h0000_00A5);
        access(32'hf800_0000, 32'h0, 4'b0000, 0);
        // Strobe on a byte beyond the register width leaves it untouched
        access(32'hf800_0000, 32'h1234_5600, 4'b0010, 0);
        // Scratch RAM read with three wait cycles
        access(32'hf820_0010, 32'h0, 4'b0000, 3);
        // ILA never answers
        access(32'hf818_0004, 32'h0, 4'b0000, NEVER);
        // Unmapped addresses
        access(32'h1234_5678, 32'h0, 4'b0000, 0);
        access(32'hf800_0004, 32'h0, 4'b0000, 0);
        // ILA ready on the very cycle the timeout would fire
        access(32'hf810_0000, 32'h0, 4'b0000, T - 1);

        // Reset in the middle of a scratch RAM access
        bif.bus_valid = 1'b1;
        bif.bus_addr  = 32'hf820_0020;
        bif.bus_wdata = 32'h0;
        bif.bus_wstrb = 4'b0000;
        @(negedge clk);
        bif.bus_valid = 1'b0;
        @(negedge clk);
        check("mid_sram_sel", {31'h0, bif.sram_sel}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        model_rc = RINIT;
        check("abort_sram_sel", {31'h0, bif.sram_sel}, 32'h0);
        check("abort_ready", {31'h0, bif.bus_ready}, 32'h0);
        check("abort_rst_ctrl", {24'h0, rst_ctrl}, {24'h0, RINIT});
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ready", {31'h0, bif.bus_ready}, 32'h0);
        end
        access(32'hf820_0020, 32'hCAFE_F00D, 4'b1111, 1);

        // Random mix across all regions
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: a = 32'hf800_0000;
                1: a = {12'hf80, 20'($urandom_range(1, 20'hF_FFFF))};
                2: a = {12'hf81, 20'($urandom)};
                3: a = {12'hf82, 20'($urandom)};
                default: begin
                    a = $urandom;
                    if (a[31:20] inside {12'hf80, 12'hf81, 12'hf82}) a[31] = 1'b0;
                end
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            w  = $urandom_range(0, 5);
            if ($urandom_range(0, 24) == 0) w = NEVER;
            if ($urandom_range(0, 24) == 0) w = T - 1;
            access(a, $urandom, ws, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
